// File: rtl/spart_pkg.sv
// Shared definitions for the SPART responder: register map, FSM states
// and STATUS register bit positions.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    localparam int STAT_RDA = 0;
    localparam int STAT_TBR = 1;
    localparam int STAT_FE  = 2;
    localparam int STAT_OVR = 3;

    // Each bit spans 16 ticks; the receiver re-centres on the start bit at tick 8.
    localparam logic [3:0] TICK_LAST = 4'd15;
    localparam logic [3:0] TICK_MID  = 4'd7;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/spart_baud_gen.sv
// 16x oversampling tick generator: one tick every 'divisor' clocks,
// silent while divisor is zero, phase restarted on request.
module spart_baud_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] divisor,
    input  logic        restart,
    output logic        tick
);

    logic [15:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (restart || (divisor == 16'd0)) begin
            r_count <= '0;
        end else if (r_count >= divisor) begin
            r_count <= 16'd1;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    assign tick = (divisor != 16'd0) && (r_count == divisor);

endmodule

// File: rtl/spart_responder.sv
// SPART responder: bus-mapped 8N1 UART with a double-buffered transmitter
// and a single-byte receive buffer reporting overrun and framing errors.
module spart_responder
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'h0144
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic        w_rdEn;
    logic        w_wrEn;
    logic        w_dataRead;
    logic        w_statRead;
    logic        w_dataWrite;
    logic        w_divWrite;
    logic        w_tick;
    logic [7:0]  w_rdData;
    logic [7:0]  w_status;
    logic [15:0] r_divisor;

    logic        r_tbr;
    logic [7:0]  r_txBuf;
    logic [7:0]  r_txShift;
    logic [3:0]  r_txTickCnt;
    logic [2:0]  r_txBitCnt;
    tx_state_e   r_txState;
    tx_state_e   w_txNext;
    logic        w_txLoad;
    logic        w_txBitEnd;
    logic        w_txd;

    logic        r_rxSync1;
    logic        r_rxSync2;
    rx_state_e   r_rxState;
    rx_state_e   w_rxNext;
    logic [3:0]  r_rxTickCnt;
    logic [2:0]  r_rxBitCnt;
    logic [7:0]  r_rxShift;
    logic [7:0]  r_rxBuf;
    logic        w_rxCntClr;
    logic        w_rxShiftEn;
    logic        w_rxGood;
    logic        w_rxBad;
    logic        r_rda;
    logic        r_ovr;
    logic        r_fe;

    assign w_rdEn      = iocs & iorw;
    assign w_wrEn      = iocs & ~iorw;
    assign w_dataRead  = w_rdEn && (ioaddr == ADDR_DATA);
    assign w_statRead  = w_rdEn && (ioaddr == ADDR_STATUS);
    assign w_dataWrite = w_wrEn && (ioaddr == ADDR_DATA);
    assign w_divWrite  = w_wrEn && ((ioaddr == ADDR_DIV_LO) || (ioaddr == ADDR_DIV_HI));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_divisor <= DIV_RESET;
        end else if (w_wrEn && (ioaddr == ADDR_DIV_LO)) begin
            r_divisor[7:0] <= databus;
        end else if (w_wrEn && (ioaddr == ADDR_DIV_HI)) begin
            r_divisor[15:8] <= databus;
        end
    end

    spart_baud_gen u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .divisor (r_divisor),
        .restart (w_divWrite),
        .tick    (w_tick)
    );

    always_comb begin
        w_status           = 8'h00;
        w_status[STAT_RDA] = r_rda;
        w_status[STAT_TBR] = r_tbr;
        w_status[STAT_FE]  = r_fe;
        w_status[STAT_OVR] = r_ovr;
        case (ioaddr)
            ADDR_DATA:   w_rdData = r_rxBuf;
            ADDR_STATUS: w_rdData = w_status;
            default:     w_rdData = 8'h00;
        endcase
    end

    assign databus = w_rdEn ? w_rdData : 8'hzz;

    // Transmitter: the buffer is handed to the shifter whenever the line is free.
    assign w_txBitEnd = w_tick && (r_txTickCnt == TICK_LAST);

    always_comb begin
        w_txNext = r_txState;
        w_txLoad = 1'b0;
        w_txd    = 1'b1;
        case (r_txState)
            TX_IDLE: begin
                if (!r_tbr) begin
                    w_txNext = TX_START;
                    w_txLoad = 1'b1;
                end
            end
            TX_START: begin
                w_txd = 1'b0;
                if (w_txBitEnd) w_txNext = TX_DATA;
            end
            TX_DATA: begin
                w_txd = r_txShift[0];
                if (w_txBitEnd && (r_txBitCnt == 3'd7)) w_txNext = TX_STOP;
            end
            TX_STOP: begin
                if (w_txBitEnd) begin
                    if (!r_tbr) begin
                        w_txNext = TX_START;
                        w_txLoad = 1'b1;
                    end else begin
                        w_txNext = TX_IDLE;
                    end
                end
            end
            default: w_txNext = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txState   <= TX_IDLE;
            r_tbr       <= 1'b1;
            r_txBuf     <= 8'h00;
            r_txShift   <= 8'h00;
            r_txTickCnt <= 4'd0;
            r_txBitCnt  <= 3'd0;
        end else begin
            r_txState <= w_txNext;
            if (w_txLoad) begin
                r_tbr <= 1'b1;
            end else if (w_dataWrite && r_tbr) begin
                r_tbr   <= 1'b0;
                r_txBuf <= databus;
            end
            if (w_txLoad) begin
                r_txShift   <= r_txBuf;
                r_txTickCnt <= 4'd0;
                r_txBitCnt  <= 3'd0;
            end else if ((r_txState != TX_IDLE) && w_tick) begin
                r_txTickCnt <= r_txTickCnt + 4'd1;
                if (w_txBitEnd && (r_txState == TX_DATA)) begin
                    r_txShift  <= {1'b1, r_txShift[7:1]};
                    r_txBitCnt <= r_txBitCnt + 3'd1;
                end
            end
        end
    end

    assign txd = w_txd;
    assign tbr = r_tbr;

    // Receiver: rxd is asynchronous, so only the second sync flop is ever used.
    always_comb begin
        w_rxNext    = r_rxState;
        w_rxCntClr  = 1'b0;
        w_rxShiftEn = 1'b0;
        w_rxGood    = 1'b0;
        w_rxBad     = 1'b0;
        case (r_rxState)
            RX_IDLE: begin
                if (!r_rxSync2) begin
                    w_rxNext   = RX_START;
                    w_rxCntClr = 1'b1;
                end
            end
            RX_START: begin
                if (w_tick && (r_rxTickCnt == TICK_MID)) begin
                    w_rxCntClr = 1'b1;
                    w_rxNext   = r_rxSync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_tick && (r_rxTickCnt == TICK_LAST)) begin
                    w_rxShiftEn = 1'b1;
                    if (r_rxBitCnt == 3'd7) w_rxNext = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_tick && (r_rxTickCnt == TICK_LAST)) begin
                    w_rxNext = RX_IDLE;
                    w_rxGood = r_rxSync2;
                    w_rxBad  = ~r_rxSync2;
                end
            end
            default: w_rxNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxSync1   <= 1'b1;
            r_rxSync2   <= 1'b1;
            r_rxState   <= RX_IDLE;
            r_rxTickCnt <= 4'd0;
            r_rxBitCnt  <= 3'd0;
            r_rxShift   <= 8'h00;
            r_rxBuf     <= 8'h00;
        end else begin
            r_rxSync1 <= rxd;
            r_rxSync2 <= r_rxSync1;
            r_rxState <= w_rxNext;
            if (w_rxCntClr) begin
                r_rxTickCnt <= 4'd0;
                r_rxBitCnt  <= 3'd0;
            end else if ((r_rxState != RX_IDLE) && w_tick) begin
                r_rxTickCnt <= r_rxTickCnt + 4'd1;
            end
            if (w_rxShiftEn) begin
                r_rxShift  <= {r_rxSync2, r_rxShift[7:1]};
                r_rxBitCnt <= r_rxBitCnt + 3'd1;
            end
            if (w_rxGood) r_rxBuf <= r_rxShift;
        end
    end

    // A byte landing on the same edge as a DATA read counts as fresh, not overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rda <= 1'b0;
            r_ovr <= 1'b0;
            r_fe  <= 1'b0;
        end else begin
            if (w_rxGood) begin
                r_rda <= 1'b1;
            end else if (w_dataRead) begin
                r_rda <= 1'b0;
            end
            if (w_rxGood && r_rda && !w_dataRead) begin
                r_ovr <= 1'b1;
            end else if (w_statRead) begin
                r_ovr <= 1'b0;
            end
            if (w_rxBad) begin
                r_fe <= 1'b1;
            end else if (w_statRead) begin
                r_fe <= 1'b0;
            end
        end
    end

    assign rda = r_rda;

endmodule

// File: tb/tb_spart_responder.sv
// Randomised scoreboard bench for spart_responder: bus reads and serial
// TX frames are checked by monitors against an abstract register model.
module tb_spart_responder;

    localparam logic [1:0] A_DATA   = 2'b00;
    localparam logic [1:0] A_STATUS = 2'b01;
    localparam logic [1:0] A_DIV_LO = 2'b10;
    localparam logic [1:0] A_DIV_HI = 2'b11;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       iocs    = 1'b0;
    logic       iorw    = 1'b0;
    logic [1:0] ioaddr  = 2'b00;
    logic       rxd     = 1'b1;
    logic       drvEn   = 1'b0;
    logic [7:0] drvData = 8'h00;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;
    logic       txd;

    int checks = 0;
    int fails  = 0;
    int curDiv = 16'h0144;

    bit         mRda   = 1'b0;
    bit         mOvr   = 1'b0;
    bit         mFe    = 1'b0;
    logic [7:0] mRxBuf = 8'h00;

    logic [7:0] rdExpQ[$];
    string      rdNameQ[$];
    logic [7:0] txExpQ[$];

    assign databus = drvEn ? drvData : 8'hzz;

    always #5 clk = ~clk;

    spart_responder #(.DIV_RESET(16'h0144)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 8'h%h, expected 8'h%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic got, input logic exp);
        checkOutput(name, {7'b0, got}, {7'b0, exp});
    endtask

    function automatic logic [7:0] statusExp();
        return {4'b0000, mOvr, mFe, 1'b1, mRda};
    endfunction

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; drvData = d; drvEn = 1'b1;
        @(posedge clk);
        #1;
        iocs = 1'b0; drvEn = 1'b0;
    endtask

    task automatic busRead(input logic [1:0] a, input logic [7:0] exp, input string nm);
        rdExpQ.push_back(exp);
        rdNameQ.push_back(nm);
        @(posedge clk);
        #1;
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        @(posedge clk);
        #1;
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic readData(input string nm);
        busRead(A_DATA, mRxBuf, nm);
        mRda = 1'b0;
    endtask

    task automatic readStatus(input string nm);
        busRead(A_STATUS, statusExp(), nm);
        mOvr = 1'b0;
        mFe  = 1'b0;
    endtask

    task automatic setDiv(input int d);
        busWrite(A_DIV_LO, d[7:0]);
        busWrite(A_DIV_HI, d[15:8]);
        curDiv = d;
    endtask

    task automatic checkBusReleased(input string nm);
        iocs = 1'b0; iorw = 1'b1; ioaddr = A_STATUS;
        drvEn = 1'b1; drvData = 8'hA5;
        @(negedge clk);
        checkOutput({nm, "_a5"}, databus, 8'hA5);
        drvData = 8'h00;
        @(negedge clk);
        checkOutput({nm, "_00"}, databus, 8'h00);
        drvEn = 1'b0; iorw = 1'b0;
    endtask

    task automatic driveRxFrame(input logic [7:0] b, input bit stopOk, input int d);
        int bt;
        bt = 16 * d;
        rxd = 1'b0;
        waitClk(bt);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            waitClk(bt);
        end
        if (stopOk) begin
            rxd = 1'b1;
            waitClk(bt);
        end else begin
            rxd = 1'b0;
            waitClk(12 * d);
            rxd = 1'b1;
            waitClk(bt);
        end
        rxd = 1'b1;
        waitClk(4 * d);
    endtask

    task automatic sendRxFrame(input logic [7:0] b, input bit stopOk);
        driveRxFrame(b, stopOk, curDiv);
        if (stopOk) begin
            if (mRda) mOvr = 1'b1;
            mRda   = 1'b1;
            mRxBuf = b;
        end else begin
            mFe = 1'b1;
        end
    endtask

    task automatic waitTxDrain();
        int budget;
        budget = 16 * curDiv * 12 * (txExpQ.size() + 1) + 100;
        while ((txExpQ.size() > 0) && (budget > 0)) begin
            @(posedge clk);
            budget--;
        end
        checkBit("tx_drain_in_time", txExpQ.size() == 0, 1'b1);
        txExpQ.delete();
        waitClk(16 * curDiv);
    endtask

    task automatic applyStimulus(input int op);
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        case (op)
            0: begin
                sendRxFrame(b, $urandom_range(0, 4) != 0);
                checkBit("rand_rda_port", rda, mRda);
            end
            1: readData("rand_data_read");
            2: readStatus("rand_status_read");
            default: begin
                txExpQ.push_back(b);
                busWrite(A_DATA, b);
                checkBit("rand_tbr_low", tbr, 1'b0);
                waitTxDrain();
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (iocs && iorw) begin
            if (rdExpQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL read_unexpected: got 8'h%h, expected no read", databus);
            end else begin
                checkOutput(rdNameQ.pop_front(), databus, rdExpQ.pop_front());
            end
        end
    end

    initial begin : txMonitor
        logic [7:0] got;
        logic       startBit;
        logic       stopBit;
        bit         sawReset;
        int         d;
        forever begin
            @(negedge clk);
            if (rst_n && (txd == 1'b0)) begin
                d        = curDiv;
                sawReset = 1'b0;
                got      = 8'h00;
                startBit = 1'b1;
                stopBit  = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    repeat ((k == 0) ? 8 * d : 16 * d) begin
                        @(negedge clk);
                        if (!rst_n) sawReset = 1'b1;
                    end
                    if (k == 0) startBit = txd;
                    else if (k < 9) got[k-1] = txd;
                    else stopBit = txd;
                end
                if (!sawReset) begin
                    if (txExpQ.size() == 0) begin
                        checks++;
                        fails++;
                        $display("[TB] FAIL tx_unexpected_frame: got 8'h%h, expected no frame", got);
                    end else begin
                        checkOutput("tx_frame_data", got, txExpQ.pop_front());
                        checkBit("tx_start_bit", startBit, 1'b0);
                        checkBit("tx_stop_bit", stopBit, 1'b1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        fails++;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin : mainSeq
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        @(negedge clk);
        checkBit("reset_txd", txd, 1'b1);
        checkBit("reset_tbr", tbr, 1'b1);
        checkBit("reset_rda", rda, 1'b0);
        checkBusReleased("reset_bus_released");
        readStatus("reset_status");
        readData("reset_data");
        busRead(A_DIV_LO, 8'h00, "div_lo_read");
        busRead(A_DIV_HI, 8'h00, "div_hi_read");

        setDiv(2);
        txExpQ.push_back(8'h55);
        busWrite(A_DATA, 8'h55);
        checkBit("tx55_tbr_low", tbr, 1'b0);
        waitClk(1);
        checkBit("tx55_tbr_back", tbr, 1'b1);
        waitTxDrain();

        sendRxFrame(8'hA3, 1'b1);
        checkBit("rxa3_rda_set", rda, 1'b1);
        readData("rxa3_data");
        checkBit("rxa3_rda_cleared", rda, 1'b0);

        rxd = 1'b0;
        waitClk(4 * curDiv);
        rxd = 1'b1;
        waitClk(32 * curDiv);
        checkBit("glitch_rda", rda, 1'b0);
        readStatus("glitch_status");

        sendRxFrame(8'h6E, 1'b0);
        checkBit("badstop_rda", rda, 1'b0);
        readStatus("badstop_status_fe");
        readStatus("badstop_status_cleared");

        sendRxFrame(8'h11, 1'b1);
        sendRxFrame(8'h22, 1'b1);
        readStatus("overrun_status");
        readData("overrun_data");

        busWrite(A_STATUS, 8'hFF);
        readStatus("status_write_ignored");

        txExpQ.push_back(8'h3C);
        txExpQ.push_back(8'hC3);
        busWrite(A_DATA, 8'h3C);
        waitClk(1);
        busWrite(A_DATA, 8'hC3);
        checkBit("b2b_tbr_full", tbr, 1'b0);
        busWrite(A_DATA, 8'h99);
        checkBit("b2b_tbr_still_full", tbr, 1'b0);
        waitTxDrain();

        setDiv(0);
        driveRxFrame(8'h5A, 1'b1, 2);
        checkBit("div0_no_rx", rda, 1'b0);
        setDiv(2);
        waitClk(40);
        readStatus("div0_status");
        sendRxFrame(8'hC5, 1'b1);
        readData("div0_recovered_data");

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) setDiv(int'($urandom_range(1, 3)));
            applyStimulus(int'($urandom_range(0, 3)));
        end

        setDiv(2);
        sendRxFrame(8'h81, 1'b1);
        busWrite(A_DATA, 8'hF0);
        rxd = 1'b0;
        waitClk(80);
        checkBit("prereset_txd_low", txd, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkBit("async_reset_txd", txd, 1'b1);
        checkBit("async_reset_tbr", tbr, 1'b1);
        checkBit("async_reset_rda", rda, 1'b0);
        mRda = 1'b0; mOvr = 1'b0; mFe = 1'b0; mRxBuf = 8'h00;
        curDiv = 16'h0144;
        rxd = 1'b1;
        waitClk(2);
        rst_n = 1'b1;
        setDiv(2);
        waitClk(400);
        checkBit("postreset_rda", rda, 1'b0);
        readStatus("postreset_status");
        readData("postreset_data");

        waitClk(4);
        checkBit("read_queue_drained", rdExpQ.size() == 0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/spart_responder.md
SPART_RESPONDER -- requirements
Module: spart_responder

Interface
REQ-001 SHALL have parameter DIV_RESET, default 16'h0144, the divisor value loaded at reset.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port iocs  input  1  chip select; a bus access occurs in any cycle with iocs=1.
REQ-005 SHALL have port iorw  input  1  access direction: 1=read (responder drives the bus), 0=write.
REQ-006 SHALL have port ioaddr  input  2  register select: 00 DATA, 01 STATUS, 10 DIV_LO, 11 DIV_HI.
REQ-007 SHALL have port databus  inout  8  shared data bus; driven only when iocs=1 and iorw=1, high-Z otherwise.
REQ-008 SHALL have port rda  output  1  receive data available.
REQ-009 SHALL have port tbr  output  1  transmit buffer ready (empty).
REQ-010 SHALL have port txd  output  1  serial transmit line, idle high.
REQ-011 SHALL have port rxd  input  1  serial receive line, asynchronous to clk.

Function
REQ-012 SHALL drive read data combinationally in the access cycle: DATA=rx buffer; STATUS={4'b0, overrun, frame_err, tbr, rda}; DIV_LO/DIV_HI=8'h00.
REQ-013 SHALL capture write data on the rising edge ending the access cycle: DATA loads the tx buffer; DIV_LO/DIV_HI load the divisor byte; a STATUS write is ignored.
REQ-014 SHALL clear rda on the edge ending a DATA read, and clear overrun and frame_err on the edge ending a STATUS read.
REQ-015 SHALL ignore a DATA write while tbr=0 (byte dropped; no state change).
REQ-016 SHALL generate a 16x tick every DIV clocks (a counter counting 1..DIV); DIV=0 SHALL produce no ticks; a write to either divisor byte SHALL restart the counter.
REQ-017 SHALL frame 8N1, LSB first, with every bit lasting 16 ticks.
REQ-018 TX SHALL be double-buffered: tbr drops the cycle after a DATA write; in TX IDLE the buffer moves to the shifter on the next clk and tbr returns to 1.
REQ-019 TX FSM SHALL follow IDLE->START(txd=0)->DATA(8 bits)->STOP(txd=1)->IDLE, or go straight to START if the buffer is full at the end of STOP.
REQ-020 SHALL synchronise rxd through 2 flops before any use.
REQ-021 RX FSM SHALL follow IDLE->START when the synchronised rxd=0; after 8 ticks in START, rxd=1 SHALL return it to IDLE (glitch), otherwise it SHALL enter DATA.
REQ-022 In DATA, SHALL sample each bit every 16 ticks (mid-bit); after 8 bits SHALL enter STOP and sample after 16 ticks.
REQ-023 On stop=1, SHALL load the rx buffer and set rda; if rda was already 1, SHALL also set overrun (new byte overwrites).
REQ-024 On stop=0, SHALL set frame_err, discard the byte and leave rda unchanged; SHALL return to IDLE after STOP in either case.
REQ-025 If a DATA read and a frame completion fall on the same edge, SHALL load the new byte with rda=1 and overrun=0.
REQ-026 A divisor write mid-frame SHALL take effect immediately, with no protection of the frame in flight.

Reset
REQ-027 On rst_n=0, SHALL immediately set txd=1, tbr=1, rda=0, overrun=0, frame_err=0, both FSMs=IDLE, tick counter=0, buffers=8'h00, divisor=DIV_RESET, and release the bus.
REQ-028 Reset mid-frame SHALL abort both frames, with no partial byte delivered.

Structure
REQ-029 Package spart_pkg SHALL hold the ioaddr constants (DATA, STATUS, DIV_LO, DIV_HI), the TX/RX state enums, and the status bit positions.
REQ-030 The baud tick generator SHALL be the sub-module spart_baud_gen (ports clk, rst_n, divisor, restart, tick).

Verification
REQ-031 Reset, then STATUS read -> 8'h02, txd=1, databus Z when iocs=0.
REQ-032 Write DIV_LO=02, DIV_HI=00, then DATA=8'h55 -> txd 0 for 32 clks, then bits 1,0,1,0,1,0,1,0 at 32 clks each, then stop 1; tbr low for one cycle.
REQ-033 Drive a 0xA3 frame on rxd at 32 clks/bit -> rda=1 by the end of stop; DATA read returns 8'hA3; rda=0 the next cycle.
REQ-034 Pulse rxd low for 4 ticks (8 clks) -> RX returns to IDLE, rda stays 0.
REQ-035 Frame with stop bit 0 -> rda=0; STATUS read returns bit2=1; a second STATUS read returns bit2=0.
REQ-036 Frames 0x11 then 0x22 with no read between -> DATA read returns 8'h22; STATUS read before it shows bit3=1 and rda=1.
